// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, loader state encoding and the bit-reverse
// helper used across the FFT datapath.
//   FFT_POINTS / ADDR_W / DATA_WIDTH : default frame geometry
//   fft_ld_state_e                   : input-loader FSM encoding
//   bitrev()                         : ADDR_W-bit index reversal
package fft_pkg;

  localparam int FFT_POINTS = 512;
  localparam int ADDR_W     = $clog2(FFT_POINTS);
  localparam int DATA_WIDTH = 48;

  typedef enum logic [1:0] {
    ST_LOAD      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } fft_ld_state_e;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] idx);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = idx[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// fft_input_loader_if: groups the sample stream, the engine-done pulse and
// the working-RAM write port of the input loader.
//   slave modport  : the loader (consumes samples, drives RAM write + status)
//   master modport : the sample source / RAM side
// Handshake: i_sample_valid is a one-cycle strobe with no back-pressure; a
// sample is taken only when the loader is in LOAD, otherwise it is counted
// as dropped. o_ram_wr_en qualifies o_ram_addr/o_ram_data for one cycle.
interface fft_input_loader_if #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int DATA_WIDTH     = 48,
  parameter int ADDR_W         = 9,
  parameter int DROP_CNT_WIDTH = 16
);
  import fft_pkg::*;

  logic                      i_sample_valid;
  logic [SAMPLE_WIDTH-1:0]   i_sample;
  logic                      i_fft_done;
  logic [ADDR_W-1:0]         o_ram_addr;
  logic [DATA_WIDTH-1:0]     o_ram_data;
  logic                      o_ram_wr_en;
  logic                      o_frame_start;
  logic                      o_loading;
  logic [ADDR_W-1:0]         o_sample_idx;
  logic [DROP_CNT_WIDTH-1:0] o_drop_count;
  fft_ld_state_e             o_state;

  modport slave (
    input  i_sample_valid, i_sample, i_fft_done,
    output o_ram_addr, o_ram_data, o_ram_wr_en, o_frame_start,
           o_loading, o_sample_idx, o_drop_count, o_state
  );

  modport master (
    output i_sample_valid, i_sample, i_fft_done,
    input  o_ram_addr, o_ram_data, o_ram_wr_en, o_frame_start,
           o_loading, o_sample_idx, o_drop_count, o_state
  );

endinterface

// File: rtl/fft_bit_reverse.sv
// fft_bit_reverse: purely combinational ADDR_W-bit index reversal.
//   i_idx  : natural-order index
//   o_addr : bit-reversed address (bit i of o_addr = bit ADDR_W-1-i of i_idx)
module fft_bit_reverse #(
  parameter int ADDR_W = 9
) (
  input  logic [ADDR_W-1:0] i_idx,
  output logic [ADDR_W-1:0] o_addr
);

  always_comb begin
    o_addr = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      o_addr[i] = i_idx[ADDR_W-1-i];
    end
  end

endmodule

// File: rtl/fft_input_loader.sv
// fft_input_loader: loads one frame of real samples into the FFT working RAM
// at bit-reversed addresses as {sext(sample), zero imaginary}, pulses
// o_frame_start after the last write and drops input until i_fft_done.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave side of fft_input_loader_if (stream in, RAM write out,
//                status: o_loading, o_sample_idx, o_drop_count, o_state)
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int DATA_WIDTH     = fft_pkg::DATA_WIDTH,
  parameter int FFT_POINTS     = fft_pkg::FFT_POINTS,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  fft_input_loader_if.slave      bus
);

  localparam int ADDR_W = $clog2(FFT_POINTS);
  localparam int HALF   = DATA_WIDTH / 2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FFT_POINTS - 1);

  fft_ld_state_e             state_q, state_d;
  logic [ADDR_W-1:0]         idx_q, idx_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      wr_en_q, wr_en_d;
  logic                      start_q, start_d;
  logic                      loading_q, loading_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic [ADDR_W-1:0]         rev_idx;
  logic signed [HALF-1:0]    sample_re;

  fft_bit_reverse #(.ADDR_W(ADDR_W)) u_bit_reverse (
    .i_idx  (idx_q),
    .o_addr (rev_idx)
  );

  assign sample_re = HALF'($signed(bus.i_sample));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_en_d   = 1'b0;
    start_d   = 1'b0;
    drop_d    = drop_q;

    unique case (state_q)
      ST_LOAD: begin
        if (bus.i_sample_valid) begin
          wr_en_d = 1'b1;
          addr_d  = rev_idx;
          data_d  = {sample_re, {HALF{1'b0}}};
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_START;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_START: begin
        // Registered pulse lands one cycle after the final write strobe.
        start_d = 1'b1;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.i_fft_done) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    // Any sample outside LOAD is lost; the count sticks at all-ones.
    if (bus.i_sample_valid && (state_q != ST_LOAD) && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end

    // o_loading falls together with o_frame_start and rises the cycle after
    // i_fft_done is sampled, so it tracks the next state but keeps START
    // counted as still loading.
    loading_d = (state_d == ST_LOAD) || (state_d == ST_START);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_LOAD;
      idx_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      start_q   <= 1'b0;
      loading_q <= 1'b1;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      start_q   <= start_d;
      loading_q <= loading_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.o_ram_addr    = addr_q;
  assign bus.o_ram_data    = data_q;
  assign bus.o_ram_wr_en   = wr_en_q;
  assign bus.o_frame_start = start_q;
  assign bus.o_loading     = loading_q;
  assign bus.o_sample_idx  = idx_q;
  assign bus.o_drop_count  = drop_q;
  assign bus.o_state       = state_q;

endmodule

// File: tb/tb_fft_input_loader.sv
module tb_fft_input_loader;
  import fft_pkg::*;

  logic clk;
  logic reset;

  fft_input_loader_if #(.SAMPLE_WIDTH(16), .DATA_WIDTH(48), .ADDR_W(9), .DROP_CNT_WIDTH(16)) bus ();
  fft_input_loader_if #(.SAMPLE_WIDTH(16), .DATA_WIDTH(48), .ADDR_W(2), .DROP_CNT_WIDTH(4)) bus2 ();

  fft_input_loader #(.SAMPLE_WIDTH(16), .DATA_WIDTH(48), .FFT_POINTS(512), .DROP_CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  fft_input_loader #(.SAMPLE_WIDTH(16), .DATA_WIDTH(48), .FFT_POINTS(4), .DROP_CNT_WIDTH(4)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fs_pulses;

  typedef struct {
    logic [15:0] sample;
    logic [47:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] br9(input logic [8:0] x);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) r[i] = x[8-i];
    return r;
  endfunction

  function automatic logic [47:0] exp_word(input logic [15:0] s);
    return {{8{s[15]}}, s, 24'h0};
  endfunction

  task automatic drive(input logic v, input logic [15:0] s, input logic d);
    bus.i_sample_valid = v;
    bus.i_sample       = s;
    bus.i_fft_done     = d;
  endtask

  // Accept one sample on the big DUT and check its write.
  task automatic load_one(input int k, input logic [15:0] s, input bit chk_data);
    drive(1'b1, s, 1'b0);
    step();
    if (bus.o_frame_start) fs_pulses++;
    check("wr_en", {63'b0, bus.o_ram_wr_en}, 64'd1);
    check("addr", {55'b0, bus.o_ram_addr}, {55'b0, br9(9'(k))});
    if (chk_data) check("data", {16'b0, bus.o_ram_data}, {16'b0, exp_word(s)});
  endtask

  initial begin
    drive(1'b0, 16'h0, 1'b0);
    bus2.i_sample_valid = 1'b0;
    bus2.i_sample       = 16'h0;
    bus2.i_fft_done     = 1'b0;

    vecs[0] = '{16'h0000, 48'h000000_000000};
    vecs[1] = '{16'hFFFF, 48'hFFFFFF_000000};
    vecs[2] = '{16'h7FFF, 48'h007FFF_000000};
    vecs[3] = '{16'h8000, 48'hFF8000_000000};
    vecs[4] = '{16'h1234, 48'h001234_000000};
    vecs[5] = '{16'hC001, 48'hFFC001_000000};

    // reset state
    reset = 1'b1;
    step();
    check("rst_addr", {55'b0, bus.o_ram_addr}, 64'd0);
    check("rst_data", {16'b0, bus.o_ram_data}, 64'd0);
    check("rst_wr_en", {63'b0, bus.o_ram_wr_en}, 64'd0);
    check("rst_frame_start", {63'b0, bus.o_frame_start}, 64'd0);
    check("rst_loading", {63'b0, bus.o_loading}, 64'd1);
    check("rst_idx", {55'b0, bus.o_sample_idx}, 64'd0);
    check("rst_drop", {48'b0, bus.o_drop_count}, 64'd0);
    reset = 1'b0;

    // full frame 0..511
    fs_pulses = 0;
    for (int k = 0; k < 512; k++) begin
      load_one(k, 16'(k), 1'b1);
      if (k == 1) check("addr_s1_256", {55'b0, bus.o_ram_addr}, 64'd256);
      if (k == 2) check("addr_s2_128", {55'b0, bus.o_ram_addr}, 64'd128);
      if (k == 511) check("addr_s511", {55'b0, bus.o_ram_addr}, 64'd511);
    end
    check("frame_start_during_last_write", {63'b0, bus.o_frame_start}, 64'd0);
    check("loading_during_last_write", {63'b0, bus.o_loading}, 64'd1);
    drive(1'b0, 16'h0, 1'b0);
    step();
    check("frame_start_pulse", {63'b0, bus.o_frame_start}, 64'd1);
    check("loading_low", {63'b0, bus.o_loading}, 64'd0);
    check("wr_en_after_frame", {63'b0, bus.o_ram_wr_en}, 64'd0);
    check("idx_wrap", {55'b0, bus.o_sample_idx}, 64'd0);
    step();
    check("frame_start_one_cycle", {63'b0, bus.o_frame_start}, 64'd0);

    // 10 drops in WAIT_DONE
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 16'(100 + k), 1'b0);
      step();
      check("drop_no_write", {63'b0, bus.o_ram_wr_en}, 64'd0);
    end
    check("drop_count_10", {48'b0, bus.o_drop_count}, 64'd10);

    // engine done, loading resumes
    drive(1'b0, 16'h0, 1'b1);
    step();
    check("loading_after_done", {63'b0, bus.o_loading}, 64'd1);
    drive(1'b0, 16'h0, 1'b0);
    step();

    // table-driven data vectors at the start of a new frame
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, vecs[k].sample, 1'b0);
      step();
      check("vec_wr_en", {63'b0, bus.o_ram_wr_en}, 64'd1);
      check("vec_addr", {55'b0, bus.o_ram_addr}, {55'b0, br9(9'(k))});
      check("vec_data", {16'b0, bus.o_ram_data}, {16'b0, vecs[k].exp_data});
    end
    check("drop_hold_10", {48'b0, bus.o_drop_count}, 64'd10);

    // finish the frame with random samples
    for (int k = 6; k < 512; k++) load_one(k, 16'($urandom_range(0, 65535)), 1'b1);
    drive(1'b0, 16'h0, 1'b0);
    step();
    check("frame_start_2", {63'b0, bus.o_frame_start}, 64'd1);
    step();

    // done and sample in the same WAIT_DONE cycle
    drive(1'b1, 16'h0042, 1'b1);
    step();
    check("done_sample_no_write", {63'b0, bus.o_ram_wr_en}, 64'd0);
    check("done_sample_drop", {48'b0, bus.o_drop_count}, 64'd11);
    load_one(0, 16'h0005, 1'b1);
    check("drop_hold_11", {48'b0, bus.o_drop_count}, 64'd11);

    // reset mid-frame after 300 accepted samples
    for (int k = 1; k < 300; k++) load_one(k, 16'(k * 3), 1'b0);
    check("idx_300", {55'b0, bus.o_sample_idx}, 64'd300);
    drive(1'b0, 16'h0, 1'b0);
    reset = 1'b1;
    step();
    check("midrst_idx", {55'b0, bus.o_sample_idx}, 64'd0);
    check("midrst_wr_en", {63'b0, bus.o_ram_wr_en}, 64'd0);
    check("midrst_loading", {63'b0, bus.o_loading}, 64'd1);
    reset = 1'b0;
    fs_pulses = 0;
    for (int k = 0; k < 512; k++) load_one(k, 16'($urandom_range(0, 65535)), 1'b1);
    drive(1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.o_frame_start) fs_pulses++;
      check("no_write_after_frame", {63'b0, bus.o_ram_wr_en}, 64'd0);
    end
    check("single_frame_start", 64'(fs_pulses), 64'd1);

    // small instance: 4-point frame, 4-bit saturating drop counter
    for (int k = 0; k < 4; k++) begin
      bus2.i_sample_valid = 1'b1;
      bus2.i_sample       = 16'(k + 1);
      step();
      check("small_wr_en", {63'b0, bus2.o_ram_wr_en}, 64'd1);
      check("small_addr", {62'b0, bus2.o_ram_addr}, (k == 1) ? 64'd2 : (k == 2) ? 64'd1 : 64'(k));
    end
    bus2.i_sample_valid = 1'b0;
    step();
    check("small_frame_start", {63'b0, bus2.o_frame_start}, 64'd1);
    step();
    for (int k = 1; k <= 20; k++) begin
      bus2.i_sample_valid = 1'b1;
      step();
      if (k == 14) check("small_drop_14", {60'b0, bus2.o_drop_count}, 64'd14);
      if (k == 15) check("small_drop_15", {60'b0, bus2.o_drop_count}, 64'd15);
    end
    bus2.i_sample_valid = 1'b0;
    check("small_drop_sat", {60'b0, bus2.o_drop_count}, 64'd15);
    check("small_no_write", {63'b0, bus2.o_ram_wr_en}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
